red_pitaya_asg_buf_arb: RTL

//  Write/read arbiter and sequencer for one ASG channel waveform buffer.

---
 rtl/red_pitaya_asg_buf_arb.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/red_pitaya_asg_buf_arb.sv
// Arbiter/sequencer sharing one ASG channel buffer port between CPU single-word access and DMA bursts.
// Optional feature macro: ASG_ARB_RUN_LOCK_EN (lock out CPU writes and pause DMA while the channel runs).
module red_pitaya_asg_buf_arb #(
  parameter int RSZ    = 14,
  parameter int DW     = 14,
  parameter int STARVE = 16
) (
  input  logic           dac_clk_i,
  input  logic           dac_rst_i,
  input  logic           cpu_req_i,
  input  logic           cpu_wr_i,
  input  logic [RSZ-1:0] cpu_addr_i,
  input  logic [DW-1:0]  cpu_wdata_i,
  output logic           cpu_ack_o,
  output logic [DW-1:0]  cpu_rdata_o,
  output logic           cpu_err_o,
  input  logic           dma_start_i,
  input  logic [RSZ-1:0] dma_addr_i,
  input  logic [RSZ:0]   dma_len_i,
  input  logic           dma_valid_i,
  input  logic [DW-1:0]  dma_data_i,
  output logic           dma_ready_o,
  output logic           dma_busy_o,
  output logic           dma_done_o,
  input  logic           dac_run_i,
  output logic           buf_we_o,
  output logic [RSZ-1:0] buf_addr_o,
  output logic [DW-1:0]  buf_wdata_o,
  input  logic [DW-1:0]  buf_rdata_i
);

  localparam int SW = $clog2(STARVE + 1) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CPU_WR, S_CPU_RD0, S_CPU_RD1, S_DMA
  } state_t;

  state_t         state_q;
  logic           cpu_ack_q, cpu_err_q, busy_q, done_q, we_q;
  logic [DW-1:0]  cpu_rdata_q, wdata_q;
  logic [RSZ-1:0] addr_q, addr_cnt_q;
  logic [RSZ:0]   remain_q;
  logic [SW-1:0]  starve_q, starve_d;

  logic lock, starve_hit, cpu_go, beat, last_beat;

`ifdef ASG_ARB_RUN_LOCK_EN
  assign lock = dac_run_i;
`else
  logic unused_run;
  assign unused_run = dac_run_i;
  assign lock       = 1'b0;
`endif

  assign starve_hit = (starve_q >= SW'(STARVE));
  // The CPU request is blind during its own ack cycle so one request never yields two accesses.
  assign cpu_go     = cpu_req_i & ~cpu_ack_q;
  assign starve_d   = starve_hit ? starve_q : starve_q + SW'(1);

  assign dma_ready_o = (state_q == S_DMA) & ~starve_hit & ~lock;
  assign beat        = dma_ready_o & dma_valid_i;
  assign last_beat   = beat & (remain_q == (RSZ+1)'(1));

  always_ff @(posedge dac_clk_i) begin
    if (dac_rst_i) begin
      state_q     <= S_IDLE;
      cpu_ack_q   <= 1'b0;
      cpu_err_q   <= 1'b0;
      cpu_rdata_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      addr_cnt_q  <= '0;
      remain_q    <= '0;
      starve_q    <= '0;
    end else begin
      cpu_ack_q <= 1'b0;
      cpu_err_q <= 1'b0;
      done_q    <= 1'b0;
      we_q      <= 1'b0;

      // A zero-length burst completes at once and never becomes busy.
      if (dma_start_i && !busy_q) begin
        if (dma_len_i == '0) begin
          done_q <= 1'b1;
        end else begin
          busy_q     <= 1'b1;
          addr_cnt_q <= dma_addr_i;
          remain_q   <= dma_len_i;
        end
      end

      case (state_q)
        S_IDLE: begin
          if (busy_q && !starve_hit) begin
            state_q <= S_DMA;
          end else if (cpu_go) begin
            starve_q <= '0;
            if (cpu_wr_i) begin
              state_q   <= S_CPU_WR;
              cpu_ack_q <= 1'b1;
              if (lock) begin
                cpu_err_q <= 1'b1;
              end else begin
                we_q    <= 1'b1;
                addr_q  <= cpu_addr_i;
                wdata_q <= cpu_wdata_i;
              end
            end else begin
              state_q <= S_CPU_RD0;
              addr_q  <= cpu_addr_i;
            end
          end else if (!cpu_req_i) begin
            starve_q <= '0;
          end
        end
        S_CPU_WR:  state_q <= S_IDLE;
        S_CPU_RD0: state_q <= S_CPU_RD1;
        S_CPU_RD1: begin
          state_q     <= S_IDLE;
          cpu_ack_q   <= 1'b1;
          cpu_rdata_q <= buf_rdata_i;
        end
        S_DMA: begin
          starve_q <= cpu_req_i ? starve_d : '0;
          if (beat) begin
            we_q       <= 1'b1;
            addr_q     <= addr_cnt_q;
            wdata_q    <= dma_data_i;
            addr_cnt_q <= addr_cnt_q + RSZ'(1);
            remain_q   <= remain_q - (RSZ+1)'(1);
            if (last_beat) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_IDLE;
            end
          end else if (starve_hit || !busy_q) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cpu_ack_o   = cpu_ack_q;
  assign cpu_rdata_o = cpu_rdata_q;
  assign cpu_err_o   = cpu_err_q;
  assign dma_busy_o  = busy_q;
  assign dma_done_o  = done_q;
  assign buf_we_o    = we_q;
  assign buf_addr_o  = addr_q;
  assign buf_wdata_o = wdata_q;

endmodule
